// File: rtl/tx_buf_wr_space_ctrl_pkg.sv
// Shared types and defaults for the TX buffer write-side space controller.
// Buffer depth is derived from the BF macro (2^(BF+1) qwords).
`ifndef BF
`define BF 9
`endif

package tx_buf_wr_space_ctrl_pkg;

  localparam int AW_DEF    = `BF + 1;
  localparam int LEN_W_DEF = 9;

  typedef enum logic [4:0] {
    s_idle  = 5'b00001,
    s_check = 5'b00010,
    s_grant = 5'b00100,
    s_wait  = 5'b01000,
    s_err   = 5'b10000
  } state_t;

endpackage

// File: rtl/tx_buf_free_calc.sv
// Registered free-space calculator for the TX buffer write side.
// Optional TX_SPACE_WATERMARK_EN adds a registered low-space flag.
module tx_buf_free_calc #(
  parameter int AW = 10
`ifdef TX_SPACE_WATERMARK_EN
  ,
  parameter int LOW_WM = 64
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr,
  input  logic [AW-1:0] wr_addr,
  output logic [AW-1:0] free_qw
`ifdef TX_SPACE_WATERMARK_EN
  ,
  output logic          space_low
`endif
);

  // One slot stays empty so that rd == wr means empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_qw <= '1;
    end else begin
      free_qw <= rd_addr - wr_addr - AW'(1);
    end
  end

`ifdef TX_SPACE_WATERMARK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      space_low <= 1'b0;
    end else begin
      space_low <= (32'(free_qw) < LOW_WM);
    end
  end
`endif

endmodule

// File: rtl/tx_buf_wr_space_ctrl.sv
// TX buffer write-side space controller: grants DMA writes that fit.
// Optional TX_SPACE_WATERMARK_EN exposes the space_low flag.
module tx_buf_wr_space_ctrl
  import tx_buf_wr_space_ctrl_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int LEN_W = LEN_W_DEF
`ifdef TX_SPACE_WATERMARK_EN
  ,
  parameter int LOW_WM = 64
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    commited_rd_addr_in,
  input  logic             dma_req,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_gnt,
  output logic [AW-1:0]    dma_addr,
  input  logic             dma_done,
  output logic             len_err,
  output logic [AW-1:0]    free_qw,
  output logic [AW-1:0]    commited_wr_addr_out
`ifdef TX_SPACE_WATERMARK_EN
  ,
  output logic             space_low
`endif
);

  localparam int CW = (AW > LEN_W) ? AW : LEN_W;

  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    wr_addr;
  logic [LEN_W-1:0] len_q;
  logic             len_bad;
  logic             fits;
  logic             take;

  // Legal lengths are 1 .. 2^(LEN_W-1).
  assign len_bad = (dma_len == '0) ||
                   (dma_len[LEN_W-1] && |dma_len[LEN_W-2:0]);

  assign fits = CW'(len_q) <= CW'(free_qw);
  assign take = (state_q == s_idle) && dma_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      s_idle:  if (dma_req) state_d = len_bad ? s_err : s_check;
      s_err:   if (!dma_req) state_d = s_idle;
      s_check: if (fits) state_d = s_grant;
      s_grant: state_d = s_wait;
      s_wait:  if (dma_done) state_d = s_idle;
      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= s_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      len_q   <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= take && len_bad;
      if (take) begin
        len_q <= dma_len;
      end
      if (state_q == s_wait && dma_done) begin
        wr_addr <= wr_addr + AW'(len_q);
      end
    end
  end

  // wr_addr only moves on completion, so it doubles as the
  // granted start address and the committed write address.
  assign dma_gnt              = (state_q == s_grant);
  assign dma_addr             = wr_addr;
  assign commited_wr_addr_out = wr_addr;

  tx_buf_free_calc #(
    .AW     (AW)
`ifdef TX_SPACE_WATERMARK_EN
    ,
    .LOW_WM (LOW_WM)
`endif
  ) u_free (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (commited_rd_addr_in),
    .wr_addr   (wr_addr),
    .free_qw   (free_qw)
`ifdef TX_SPACE_WATERMARK_EN
    ,
    .space_low (space_low)
`endif
  );

endmodule

// File: tb/tb_tx_buf_wr_space_ctrl.sv
// Self-checking bench for tx_buf_wr_space_ctrl (AW=10, LEN_W=9).
module tb_tx_buf_wr_space_ctrl;

  localparam int AW    = 10;
  localparam int LEN_W = 9;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [AW-1:0]    rd    = '0;
  logic             req   = 1'b0;
  logic [LEN_W-1:0] len   = '0;
  logic             done  = 1'b0;
  logic             gnt;
  logic             len_err;
  logic [AW-1:0]    addr;
  logic [AW-1:0]    free;
  logic [AW-1:0]    commit;
`ifdef TX_SPACE_WATERMARK_EN
  logic             space_low;
`endif

  int n_chk = 0;
  int n_err = 0;
  int unsigned wr_m = 0;
  int unsigned exp_addr_q[$];
  int unsigned exp_commit_q[$];

  typedef struct {
    logic [AW-1:0] rd;
    logic [AW-1:0] free;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  tx_buf_wr_space_ctrl #(
    .AW     (AW),
    .LEN_W  (LEN_W)
`ifdef TX_SPACE_WATERMARK_EN
    ,
    .LOW_WM (64)
`endif
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .commited_rd_addr_in  (rd),
    .dma_req              (req),
    .dma_len              (len),
    .dma_gnt              (gnt),
    .dma_addr             (addr),
    .dma_done             (done),
    .len_err              (len_err),
    .free_qw              (free),
    .commited_wr_addr_out (commit)
`ifdef TX_SPACE_WATERMARK_EN
    ,
    .space_low            (space_low)
`endif
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pop_addr(input string name);
    if (exp_addr_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got grant with no expectation", name);
    end else begin
      chk(name, 32'(addr), exp_addr_q.pop_front());
    end
  endtask

  task automatic pop_commit(input string name);
    if (exp_commit_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got commit with no expectation", name);
    end else begin
      chk(name, 32'(commit), exp_commit_q.pop_front());
    end
  endtask

  task automatic xfer(input int l);
    int n;
    n = 0;
    req = 1'b1;
    len = LEN_W'(l);
    exp_addr_q.push_back(wr_m);
    tick();
    while (!gnt && n < 64) begin
      tick();
      n++;
    end
    chk("xfer_gnt", 32'(gnt), 1);
    if (!gnt) begin
      req = 1'b0;
      exp_addr_q.delete();
      return;
    end
    pop_addr("xfer_addr");
    tick();
    req  = 1'b0;
    done = 1'b1;
    wr_m = (wr_m + l) % 1024;
    exp_commit_q.push_back(wr_m);
    tick();
    done = 1'b0;
    pop_commit("xfer_commit");
  endtask

  // Keep rd at wr so the buffer is empty, then step wr to target.
  task automatic fill(input int unsigned target);
    int unsigned d;
    while (wr_m != target) begin
      rd = AW'(wr_m);
      tick();
      d = (target + 1024 - wr_m) % 1024;
      xfer((d > 256) ? 256 : int'(d));
    end
  endtask

  task automatic bad_len(input int l, input string tag);
    int pulses;
    int g;
    pulses = 0;
    g = 0;
    req = 1'b1;
    len = LEN_W'(l);
    tick();
    chk({tag, "_err"}, 32'(len_err), 1);
    repeat (4) begin
      tick();
      pulses += int'(len_err);
      g |= int'(gnt);
    end
    chk({tag, "_extra_err"}, pulses, 0);
    chk({tag, "_gnt"}, g, 0);
    req = 1'b0;
    tick();
    chk({tag, "_wr"}, 32'(commit), wr_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vecs[0] = '{rd: 10'd16,   free: 10'd1023};
    vecs[1] = '{rd: 10'd17,   free: 10'd0};
    vecs[2] = '{rd: 10'd0,    free: 10'd1007};
    vecs[3] = '{rd: 10'd80,   free: 10'd63};
    vecs[4] = '{rd: 10'd81,   free: 10'd64};
    vecs[5] = '{rd: 10'd1023, free: 10'd1006};
    vecs[6] = '{rd: 10'd500,  free: 10'd483};

    repeat (2) tick();
    chk("rst_free", 32'(free), 1023);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_len_err", 32'(len_err), 0);
    chk("rst_commit", 32'(commit), 0);
`ifdef TX_SPACE_WATERMARK_EN
    chk("rst_low", 32'(space_low), 0);
`endif
    reset = 1'b0;
    tick();

    // First request: grant exactly two cycles after req.
    req = 1'b1;
    len = 9'd16;
    exp_addr_q.push_back(0);
    tick();
    chk("t1_gnt_c1", 32'(gnt), 0);
    tick();
    chk("t1_gnt_c2", 32'(gnt), 1);
    pop_addr("t1_addr");
    tick();
    chk("t1_gnt_pulse", 32'(gnt), 0);
    chk("t1_commit_pre", 32'(commit), 0);
    req  = 1'b0;
    done = 1'b1;
    exp_commit_q.push_back(16);
    tick();
    done = 1'b0;
    pop_commit("t1_commit");
    wr_m = 16;
    tick();

    for (int i = 0; i < 7; i++) begin
      rd = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_free", i), 32'(free), 32'(vecs[i].free));
    end

    // Stall on insufficient space, grant once rd advances.
    fill(1000);
    rd = 10'd1;
    tick();
    chk("t2_free24", 32'(free), 24);
    req = 1'b1;
    len = 9'd32;
    exp_addr_q.push_back(1000);
    g = 0;
    repeat (6) begin
      tick();
      g |= int'(gnt);
    end
    chk("t2_stall", g, 0);
    rd = 10'd9;
    tick();
    chk("t2_free32", 32'(free), 32);
    chk("t2_no_gnt_yet", 32'(gnt), 0);
    tick();
    chk("t2_gnt", 32'(gnt), 1);
    pop_addr("t2_addr");
    tick();
    req  = 1'b0;
    done = 1'b1;
    exp_commit_q.push_back(8);
    tick();
    done = 1'b0;
    pop_commit("t2_commit");
    wr_m = 8;

    // Transfer crossing the top of the buffer.
    fill(1016);
    rd = 10'd0;
    tick();
    chk("t3_free7", 32'(free), 7);
    rd = 10'd200;
    tick();
    chk("t3_free207", 32'(free), 207);
    xfer(16);
    chk("t3_commit_wrap", 32'(commit), 8);

    bad_len(0, "t4_len0");
    bad_len(257, "t4_len257");
    xfer(4);
    chk("t4_after_err", 32'(commit), 12);

    // Stray done in IDLE.
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("t5_stray_commit", 32'(commit), 12);
    chk("t5_stray_free", 32'(free), 187);

    // Reset while a transfer is outstanding.
    req = 1'b1;
    len = 9'd16;
    exp_addr_q.push_back(12);
    tick();
    tick();
    chk("t5_gnt", 32'(gnt), 1);
    pop_addr("t5_addr");
    tick();
    req   = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_addr", 32'(addr), 0);
    chk("t5_rst_commit", 32'(commit), 0);
    chk("t5_rst_free", 32'(free), 1023);
    chk("t5_rst_len_err", 32'(len_err), 0);
    wr_m = 0;
    tick();
    reset = 1'b0;
    rd    = 10'd0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("t5_late_done_commit", 32'(commit), 0);
    chk("t5_late_done_free", 32'(free), 1023);

`ifdef TX_SPACE_WATERMARK_EN
    rd = 10'd65;
    tick();
    tick();
    chk("wm_free64", 32'(free), 64);
    chk("wm_low_at64", 32'(space_low), 0);
    rd = 10'd64;
    tick();
    chk("wm_free63", 32'(free), 63);
    chk("wm_low_lag", 32'(space_low), 0);
    tick();
    chk("wm_low_rise", 32'(space_low), 1);
`endif

    chk("sb_empty", exp_addr_q.size() + exp_commit_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
